// File: rtl/jtopl_sh_pkg.sv
// Shared helpers for the slot delay line: pointer width derivation and legal depth check.
package jtopl_sh_pkg;

    localparam int MIN_STAGES = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit stages_ok(input int stages);
        return stages >= MIN_STAGES;
    endfunction

endpackage

// File: rtl/jtopl_sh_slots_if.sv
// Slot delay line control/data bundle; the pipeline stage drives master, the delay line is slave.
interface jtopl_sh_slots_if
    import jtopl_sh_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 18
);
    localparam int PTRW = clog2(STAGES);

    logic             cen;
    logic             clr;
    logic             hold;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] drop;
    logic [PTRW-1:0]  slot;
    logic             zero;
    logic             busy;

    modport master (
        output cen, clr, hold, din,
        input  drop, slot, zero, busy
    );

    modport slave (
        input  cen, clr, hold, din,
        output drop, slot, zero, busy
    );

endinterface

// File: rtl/jtopl_sh_ram.sv
// Slot storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: read is combinational; no backpressure, a write lands on the clock edge.
module jtopl_sh_ram #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 18,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdat,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdat
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdat;
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/jtopl_sh_slots.sv
// STAGES-deep, WIDTH-bit slot delay line on a circular buffer, with init sweep, clear and per-slot hold.
// Latency: STAGES cen cycles from din to drop; no backpressure, outputs masked while the sweep runs.
module jtopl_sh_slots
    import jtopl_sh_pkg::*;
#(
    parameter int   WIDTH  = 5,
    parameter int   STAGES = 18,
    parameter logic RSTVAL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    jtopl_sh_slots_if.slave sh
);

    localparam int              PTRW = clog2(STAGES);
    localparam logic [PTRW-1:0] LAST = PTRW'(STAGES - 1);
    localparam logic [WIDTH-1:0] FILL = {WIDTH{RSTVAL}};

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("jtopl_sh_slots: STAGES must be at least 2");
    end

    logic [PTRW-1:0]  ptr;
    logic [PTRW-1:0]  ptr_nxt;
    logic [PTRW-1:0]  swcnt;
    logic             busy;
    logic             we;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] rd;

    assign ptr_nxt = (ptr == LAST) ? '0 : ptr + PTRW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            swcnt <= '0;
            busy  <= 1'b1;
        end else if (sh.clr) begin
            ptr   <= '0;
            swcnt <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            // sweep ignores cen: every edge fills one slot until the pointer wraps
            ptr <= ptr_nxt;
            if (swcnt == LAST) begin
                swcnt <= '0;
                busy  <= 1'b0;
            end else begin
                swcnt <= swcnt + PTRW'(1);
            end
        end else if (sh.cen) begin
            ptr <= ptr_nxt;
        end
    end

    // clear wins over both sweep and normal writes on the same edge
    assign we   = !sh.clr && (busy || sh.cen);
    assign wdat = busy    ? FILL :
                  sh.hold ? rd   : sh.din;

    jtopl_sh_ram #(
        .WIDTH (WIDTH),
        .DEPTH (STAGES),
        .AW    (PTRW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr),
        .wdat  (wdat),
        .raddr (ptr),
        .rdat  (rd)
    );

    assign sh.drop = busy ? FILL : rd;
    assign sh.slot = ptr;
    assign sh.zero = !busy && (ptr == '0);
    assign sh.busy = busy;

endmodule

// File: tb/tb_jtopl_sh_slots.sv
// Scoreboard bench for jtopl_sh_slots: directed rounds on an 18-slot line and a 5-slot line.
module tb_jtopl_sh_slots;
    import jtopl_sh_pkg::*;

    typedef struct {
        logic [4:0] drop;
        logic [4:0] slot;
        logic       zero;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic rst_n_b = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    exp_t qa[$];
    exp_t qb[$];

    jtopl_sh_slots_if #(.WIDTH(5), .STAGES(18)) sa();
    jtopl_sh_slots_if #(.WIDTH(5), .STAGES(5))  sb();

    jtopl_sh_slots #(.WIDTH(5), .STAGES(18), .RSTVAL(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sh    (sa)
    );

    jtopl_sh_slots #(.WIDTH(5), .STAGES(5), .RSTVAL(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .sh    (sb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every cen cycle outside the sweep is a presented slot output.
    always @(negedge clk) begin
        exp_t e;
        if (sa.cen === 1'b1 && sa.busy === 1'b0) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: slot %0d drop %0h with empty queue at %0t", sa.slot, sa.drop, $time);
            end else begin
                e = qa.pop_front();
                check("a_drop", 32'(sa.drop), 32'(e.drop));
                check("a_slot", 32'(sa.slot), 32'(e.slot));
                check("a_zero", 32'(sa.zero), 32'(e.zero));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.cen === 1'b1 && sb.busy === 1'b0) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: slot %0d drop %0h with empty queue at %0t", sb.slot, sb.drop, $time);
            end else begin
                e = qb.pop_front();
                check("b_drop", 32'(sb.drop), 32'(e.drop));
                check("b_slot", {29'd0, sb.slot}, 32'(e.slot));
                check("b_zero", 32'(sb.zero), 32'(e.zero));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic cen, input logic hold, input logic [4:0] din,
                          input logic [4:0] ed, input logic [4:0] es);
        sa.cen  = cen;
        sa.hold = hold;
        sa.din  = din;
        if (cen) qa.push_back('{drop: ed, slot: es, zero: (es == 5'd0)});
        tick();
    endtask

    task automatic step_b(input logic [4:0] din, input logic [4:0] ed, input logic [4:0] es);
        sb.cen  = 1'b1;
        sb.hold = 1'b0;
        sb.din  = din;
        qb.push_back('{drop: ed, slot: es, zero: (es == 5'd0)});
        tick();
    endtask

    // Counts edges until busy drops (bounded); also counts sweep cycles with drop not at the fill value.
    task automatic sweep_a(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (sa.busy === 1'b1 && n < 40) begin
            if (sa.drop !== 5'h1F || sa.zero !== 1'b0) bad++;
            tick();
            n++;
        end
        sa.cen = 1'b0;
    endtask

    task automatic sweep_b(output int n);
        n = 0;
        while (sb.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        sb.cen = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        logic [4:0] v;
        sa.cen = 1'b0; sa.clr = 1'b0; sa.hold = 1'b0; sa.din = 5'h00;
        sb.cen = 1'b0; sb.clr = 1'b0; sb.hold = 1'b0; sb.din = 5'h00;
        #2;
        rst_n   = 1'b0;
        rst_n_b = 1'b0;
        #10;
        check("rst_busy", 32'(sa.busy), 32'd1);
        check("rst_drop", 32'(sa.drop), 32'h1F);
        check("rst_slot", 32'(sa.slot), 32'd0);
        check("rst_zero", 32'(sa.zero), 32'd0);
        check("rst_b_drop", 32'(sb.drop), 32'h00);

        // Sweep with cen and din active: both must be ignored
        tick();
        rst_n  = 1'b1;
        sa.cen = 1'b1;
        sa.din = 5'h00;
        sweep_a(n, bad);
        check("a_sweep_len", 32'(n), 32'd18);
        check("a_sweep_mask", 32'(bad), 32'd0);
        check("a_post_zero", 32'(sa.zero), 32'd1);
        check("a_post_slot", 32'(sa.slot), 32'd0);

        // Fill value for first round, then the slot-index pattern 18 cen later
        for (int s = 0; s < 18; s++) step_a(1'b1, 1'b0, 5'(s), 5'h1F, 5'(s));
        for (int s = 0; s < 18; s++) step_a(1'b1, 1'b0, 5'h00, 5'(s), 5'(s));

        // cen every third clock: slot only advances on cen
        for (int s = 0; s < 18; s++) begin
            step_a(1'b0, 1'b0, 5'h1B, 5'h00, 5'(s));
            step_a(1'b0, 1'b0, 5'h1B, 5'h00, 5'(s));
            check("a_slot_idle", 32'(sa.slot), 32'(s));
            step_a(1'b1, 1'b0, 5'(s) ^ 5'h10, 5'h00, 5'(s));
        end
        for (int s = 0; s < 18; s++) begin
            step_a(1'b0, 1'b0, 5'h1B, 5'h00, 5'(s));
            step_a(1'b0, 1'b0, 5'h1B, 5'h00, 5'(s));
            step_a(1'b1, 1'b0, 5'h00, 5'(s) ^ 5'h10, 5'(s));
        end

        // Hold on slots 3..5 keeps the previous round's 0A
        for (int s = 0; s < 18; s++) step_a(1'b1, 1'b0, 5'h0A, 5'h00, 5'(s));
        for (int s = 0; s < 18; s++) step_a(1'b1, (s >= 3 && s <= 5), 5'h15, 5'h0A, 5'(s));
        for (int s = 0; s < 18; s++) begin
            v = (s >= 3 && s <= 5) ? 5'h0A : 5'h15;
            step_a(1'b1, 1'b0, 5'h00, v, 5'(s));
        end

        // Clear at slot 9 mid-round
        for (int s = 0; s < 9; s++) step_a(1'b1, 1'b0, 5'h07, 5'h00, 5'(s));
        sa.clr = 1'b1;
        step_a(1'b1, 1'b0, 5'h07, 5'h00, 5'd9);
        sa.clr = 1'b0;
        check("clr_busy", 32'(sa.busy), 32'd1);
        check("clr_slot", 32'(sa.slot), 32'd0);
        sa.cen = 1'b1;
        sweep_a(n, bad);
        check("clr_sweep_len", 32'(n), 32'd18);
        check("clr_sweep_mask", 32'(bad), 32'd0);
        for (int s = 0; s < 18; s++) step_a(1'b1, 1'b0, 5'(s), 5'h1F, 5'(s));

        // Reset mid-round, then again at sweep count 7
        for (int s = 0; s < 5; s++) step_a(1'b1, 1'b0, 5'h00, 5'(s), 5'(s));
        sa.cen = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst2_busy", 32'(sa.busy), 32'd1);
        check("rst2_slot", 32'(sa.slot), 32'd0);
        check("rst2_drop", 32'(sa.drop), 32'h1F);
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check("rst3_pre_slot", 32'(sa.slot), 32'd7);
        check("rst3_pre_busy", 32'(sa.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst3_slot", 32'(sa.slot), 32'd0);
        tick();
        rst_n = 1'b1;
        sweep_a(n, bad);
        check("rst3_sweep_len", 32'(n), 32'd18);
        for (int s = 0; s < 18; s++) step_a(1'b1, 1'b0, 5'h00, 5'h1F, 5'(s));
        sa.cen = 1'b0;

        // Five-slot line: wrap 4 -> 0 and a 5-cen latency
        check("b_rst_busy", 32'(sb.busy), 32'd1);
        rst_n_b = 1'b1;
        sweep_b(n);
        check("b_sweep_len", 32'(n), 32'd5);
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 5; s++) begin
                case (r)
                    0:       step_b(5'(s + 1), 5'h00, 5'(s));
                    1:       step_b(5'(s + 8), 5'(s + 1), 5'(s));
                    default: step_b(5'h00, 5'(s + 8), 5'(s));
                endcase
            end
        end
        sb.cen = 1'b0;

        tick();
        check("a_queue_empty", 32'(qa.size()), 32'd0);
        check("b_queue_empty", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
